// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Holds the FSM state encoding, the default sync marker and the status-register error bit positions.
// Contains no logic, so it adds no latency and applies no backpressure.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PLD,
        ST_CHK,
        ST_HOLD
    } frame_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Bit positions of the sticky error flags in the decoder's status register.
    localparam int ERR_CHK_BIT     = 0;
    localparam int ERR_LEN_BIT     = 1;
    localparam int ERR_TIMEOUT_BIT = 2;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: one write port from the parser FSM and one registered read port.
// Latency: rd_data is valid one cycle after rd_addr is presented.
// Backpressure: none; a write lands every cycle wr_en is high.
module uart_frame_buf #(
    parameter int MAX_PAYLOAD = 16,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [0:MAX_PAYLOAD-1];

    // Contents deliberately survive reset so a reset does not wipe the payload.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'h00;
        end else if (32'(rd_addr) < MAX_PAYLOAD) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Hunts for SYNC, assembles SYNC CMD LEN PAYLOAD CHK frames, checks LEN and XOR checksum, holds good frames until acked.
// Latency: frame_valid rises the cycle after the CHK byte; err_* pulse the cycle after the cause. Optional inter-byte timeout: UART_FRAME_TIMEOUT_EN.
// Backpressure: rx_ready is low only while a good frame is held; frame_ack releases it.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]               SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int                       MAX_PAYLOAD    = 16,
    parameter int                       ADDR_WIDTH     = 4,
    parameter int                       TIMEOUT_WIDTH  = 20,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 20'd500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  frame_valid,
    output logic [7:0]            frame_cmd,
    output logic [7:0]            frame_len,
    input  logic                  frame_ack,
    input  logic [ADDR_WIDTH-1:0] pld_addr,
    output logic [7:0]            pld_data,
    output logic                  err_chk,
    output logic                  err_len,
    output logic                  err_timeout
);

    frame_state_t          state;
    logic [7:0]            run_chk;
    logic [7:0]            pld_cnt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rx_fire;
    logic                  tmo_hit;

    assign rx_fire = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HUNT;
            rx_ready    <= 1'b1;
            frame_valid <= 1'b0;
            frame_cmd   <= 8'h00;
            frame_len   <= 8'h00;
            run_chk     <= 8'h00;
            pld_cnt     <= 8'h00;
            wr_addr     <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            err_chk <= 1'b0;
            err_len <= 1'b0;
            if (state == ST_HOLD) begin
                if (frame_ack) begin
                    state       <= ST_HUNT;
                    frame_valid <= 1'b0;
                    rx_ready    <= 1'b1;
                end
            end else if (rx_fire) begin
                case (state)
                    ST_HUNT: if (rx_data == SYNC_BYTE) state <= ST_CMD;
                    ST_CMD: begin
                        frame_cmd <= rx_data;
                        run_chk   <= rx_data;
                        state     <= ST_LEN;
                    end
                    ST_LEN: begin
                        frame_len <= rx_data;
                        run_chk   <= run_chk ^ rx_data;
                        pld_cnt   <= 8'h00;
                        wr_addr   <= '0;
                        if (rx_data > 8'(MAX_PAYLOAD)) begin
                            err_len <= 1'b1;
                            state   <= ST_HUNT;
                        end else if (rx_data == 8'h00) begin
                            state <= ST_CHK;
                        end else begin
                            state <= ST_PLD;
                        end
                    end
                    ST_PLD: begin
                        run_chk <= run_chk ^ rx_data;
                        pld_cnt <= pld_cnt + 8'd1;
                        wr_addr <= wr_addr + 1'b1;
                        if (pld_cnt == frame_len - 8'd1) state <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (rx_data == run_chk) begin
                            state       <= ST_HOLD;
                            frame_valid <= 1'b1;
                            rx_ready    <= 1'b0;
                        end else begin
                            err_chk <= 1'b1;
                            state   <= ST_HUNT;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end else if (tmo_hit) begin
                state <= ST_HUNT;
            end
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     tmo_active;

    assign tmo_active = (state == ST_CMD) || (state == ST_LEN) ||
                        (state == ST_PLD) || (state == ST_CHK);
    // An accepted byte in the terminal cycle beats the timeout.
    assign tmo_hit = tmo_active && !rx_fire && (tmo_cnt == TIMEOUT_CYCLES - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= tmo_hit;
            if (!tmo_active || rx_fire || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    uart_frame_buf #(
        .MAX_PAYLOAD(MAX_PAYLOAD),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (rx_fire && (state == ST_PLD)),
        .wr_addr(wr_addr),
        .wr_data(rx_data),
        .rd_addr(pld_addr),
        .rd_data(pld_data)
    );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized bench for uart_frame_parser against a byte-list frame model.
module tb_uart_frame_parser;

    localparam int         MAXP = 16;
    localparam int         TMO  = 100;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       frame_ack;
    logic [3:0] pld_addr;
    logic [7:0] pld_data;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;

    uart_frame_parser #(
        .SYNC_BYTE     (SYNC),
        .MAX_PAYLOAD   (MAXP),
        .ADDR_WIDTH    (4),
        .TIMEOUT_WIDTH (20),
        .TIMEOUT_CYCLES(20'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_valid(frame_valid),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .frame_ack  (frame_ack),
        .pld_addr   (pld_addr),
        .pld_data   (pld_data),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes collected since the sync marker, plus the held frame.
    logic [7:0] cur[$];
    bit         held;
    logic [7:0] h_cmd, h_len;
    logic [7:0] h_pld [MAXP];
    bit         e_chk, e_len, e_tmo;
    int         idle;

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] x;
        if (cur.size() == 0) begin
            if (b == SYNC) cur.push_back(b);
            return;
        end
        cur.push_back(b);
        if (cur.size() == 3 && int'(cur[2]) > MAXP) begin
            e_len = 1;
            cur.delete();
        end else if (cur.size() >= 3 && cur.size() == int'(cur[2]) + 4) begin
            x = 8'h00;
            for (int i = 1; i < cur.size() - 1; i++) x ^= cur[i];
            if (x == b) begin
                held  = 1;
                h_cmd = cur[1];
                h_len = cur[2];
                for (int i = 0; i < int'(h_len); i++) h_pld[i] = cur[3 + i];
            end else begin
                e_chk = 1;
            end
            cur.delete();
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic a);
        bit acc;
        rx_valid  = v;
        rx_data   = d;
        frame_ack = a;
        check_eq("rx_ready", rx_ready, !held);
        e_chk = 0; e_len = 0; e_tmo = 0;
        acc = v && !held;
        if (held) begin
            if (a) held = 0;
        end else if (v) begin
            model_byte(d);
        end
`ifdef UART_FRAME_TIMEOUT_EN
        if (acc || held || cur.size() == 0) begin
            idle = 0;
        end else begin
            idle++;
            if (idle == TMO) begin
                e_tmo = 1;
                cur.delete();
                idle = 0;
            end
        end
`else
        idle = acc ? 0 : idle;
`endif
        @(posedge clk);
        #1;
        check_eq("frame_valid", frame_valid, held);
        check_eq("err_chk", err_chk, e_chk);
        check_eq("err_len", err_len, e_len);
        check_eq("err_timeout", err_timeout, e_tmo);
        if (held) begin
            check_eq("frame_cmd", frame_cmd, h_cmd);
            check_eq("frame_len", frame_len, h_len);
        end
        rx_valid  = 1'b0;
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cur.delete();
        held = 0;
        idle = 0;
        check_eq("rst_rx_ready", rx_ready, 1);
        check_eq("rst_frame_valid", frame_valid, 0);
        check_eq("rst_frame_cmd", frame_cmd, 0);
        check_eq("rst_frame_len", frame_len, 0);
        check_eq("rst_pld_data", pld_data, 0);
        check_eq("rst_errs", {err_chk, err_len, err_timeout}, 0);
    endtask

    // Read back some of the held payload, offer backpressured bytes, then ack.
    task automatic release_frame(input int n_reads, input int n_stall);
        for (int i = 0; i < n_reads && i < int'(h_len); i++) begin
            int k;
            k = (n_reads >= int'(h_len)) ? i : int'($urandom_range(0, int'(h_len) - 1));
            pld_addr = 4'(k);
            step(1'b0, 8'h00, 1'b0);
            check_eq("pld_data", pld_data, h_pld[k]);
        end
        for (int i = 0; i < n_stall; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'($urandom_range(0, 1)), SYNC, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (held) release_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        if ($urandom_range(0, 3) == 0) begin
            int g;
            g = int'($urandom_range(1, 3));
            for (int i = 0; i < g; i++) step(1'b0, 8'($urandom), 1'b0);
        end
        step(1'b1, b, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input bit bad, input bit ramp);
        logic [7:0] x, p;
        send_byte(SYNC);
        send_byte(cmd);
        send_byte(len);
        x = cmd ^ len;
        if (int'(len) <= MAXP) begin
            for (int i = 0; i < int'(len); i++) begin
                p = ramp ? 8'(i) : 8'($urandom);
                x ^= p;
                send_byte(p);
            end
            send_byte(bad ? ~x : x);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        frame_ack = 1'b0;
        pld_addr  = 4'd0;
        held      = 0;
        idle      = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // Good frame, read index 1, backpressure then ack.
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        check_eq("good_held", held, 1);
        pld_addr = 4'd1;
        step(1'b0, 8'h00, 1'b0);
        check_eq("good_pld1", pld_data, 8'h22);
        release_frame(2, 4);

        // Checksum error followed by a zero-length frame.
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h20);
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00); send_byte(8'h30);
        check_eq("zero_len_held", held, 1);
        release_frame(0, 1);

        // Length error after leading junk.
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
        send_byte(8'h07); send_byte(8'h11);

        // Max-length ramp frame; read every slot including 15.
        send_frame(8'h40, 8'd16, 1'b0, 1'b1);
        release_frame(16, 3);

        // Long idle mid-frame: times out when enabled, otherwise the frame completes.
        send_byte(8'hA5); send_byte(8'h10);
        for (int i = 0; i < TMO + 10; i++) step(1'b0, 8'h00, 1'b0);
        send_byte(8'h00); send_byte(8'h10);
        send_frame(8'h55, 8'd3, 1'b0, 1'b0);

        // Reset mid-payload, then reset while holding.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04); send_byte(8'h99);
        do_reset();
        send_frame(8'h66, 8'd2, 1'b0, 1'b0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        do_reset();
        send_frame(8'h77, 8'd5, 1'b0, 1'b0);

        for (int f = 0; f < 250; f++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) send_frame(8'($urandom), 8'($urandom_range(0, MAXP)), 1'b0, 1'b0);
            else if (kind == 6) send_frame(8'($urandom), 8'($urandom_range(0, MAXP)), 1'b1, 1'b0);
            else if (kind == 7) send_frame(8'($urandom), 8'($urandom_range(MAXP + 1, 255)), 1'b0, 1'b0);
            else if (kind == 8) begin
                for (int i = 0; i < 3; i++) send_byte(8'($urandom));
            end else begin
                send_byte(SYNC); send_byte(8'($urandom)); send_byte(8'd6);
                do_reset();
            end
        end
        if (held) release_frame(2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
